// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit for the MIPS CPU.
// MULT/MULTU run a shift-add over operand magnitudes and DIV/DIVU run a
// restoring shift-subtract. Each takes one iteration per clock for WIDTH
// clocks, followed by one sign-correction/commit clock. HI/LO are also
// written directly by MTHI/MTLO while the unit is idle.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WrData,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } stateT;

  stateT state;
  stateT nextState;

  // Operation context captured at Start.
  logic               isDiv;
  logic               signA;
  logic               signB;
  logic [WIDTH-1:0]   bMag;
  logic [WIDTH-1:0]   origA;

  // Working register. For multiply, the upper half holds the partial
  // product and the lower half holds the remaining multiplier bits. For
  // divide, the upper half holds the partial remainder and the lower half
  // holds the dividend bits, which are replaced by quotient bits as the
  // division proceeds.
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;

  // Launch-time operand conditioning. Signed ops take magnitudes. The
  // unsigned ops carry zero sign bits, so the correction applied later
  // does nothing for them.
  logic               startSignA;
  logic               startSignB;
  logic [WIDTH-1:0]   startAMag;
  logic [WIDTH-1:0]   startBMag;

  assign startSignA = ~Op[0] & OpA[WIDTH-1];
  assign startSignB = ~Op[0] & OpB[WIDTH-1];
  assign startAMag  = startSignA ? -OpA : OpA;
  assign startBMag  = startSignB ? -OpB : OpB;

  // One iteration of each algorithm. The second operand is always bMag.
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divShift;
  logic               divFits;
  logic [WIDTH-1:0]   divRem;
  logic [2*WIDTH-1:0] accStep;

  assign mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, bMag} : '0);
  assign divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign divFits  = divShift >= {1'b0, bMag};
  // When the divisor fits, the difference is smaller than bMag, so a
  // WIDTH-bit subtraction is exact.
  assign divRem   = divFits ? (divShift[WIDTH-1:0] - bMag) : divShift[WIDTH-1:0];
  assign accStep  = isDiv ? {divRem, acc[WIDTH-2:0], divFits}
                          : {mulSum, acc[WIDTH-1:1]};

  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   resHi;
  logic [WIDTH-1:0]   resLo;

  // Sign correction of the finished magnitudes into the HI/LO result.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path; defaults first keep latches out.
    prodFix = (signA ^ signB) ? -acc : acc;
    resHi   = prodFix[2*WIDTH-1:WIDTH];
    resLo   = prodFix[WIDTH-1:0];
    if (isDiv) begin
      if (bMag == '0) begin
        resHi = origA;
        resLo = '1;
      end else begin
        resLo = (signA ^ signB) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        resHi = signA ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state logic: launch, WIDTH iterations, then a single fix-up cycle.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (Start) nextState = RUN;
      RUN:     if (cnt == CNT_W'(WIDTH - 1)) nextState = FIX;
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge Clk) begin
    // NOTE: pure datapath registers are left out of reset; they are always loaded at Start before they are used.
    if (state == IDLE && Start) begin
      isDiv <= Op[1];
      signA <= startSignA;
      signB <= startSignB;
      bMag  <= startBMag;
      origA <= OpA;
      acc   <= {{WIDTH{1'b0}}, startAMag};
    end else if (state == RUN) begin
      acc <= accStep;
    end
  end

  // Iteration counter, HI/LO architectural registers and the completion pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt  <= '0;
      Hi   <= '0;
      Lo   <= '0;
      Done <= 1'b0;
    end else begin
      Done <= (state == FIX);
      if (state == IDLE && Start) cnt <= '0;
      else if (state == RUN)      cnt <= cnt + CNT_W'(1);
      if (state == FIX) begin
        Hi <= resHi;
        Lo <= resLo;
      end else if (state == IDLE && !Start) begin
        if (HiWrite) Hi <= WrData;
        if (LoWrite) Lo <= WrData;
      end
    end
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit. A transaction-level model
// (64-bit arithmetic plus a countdown of remaining busy cycles) predicts
// Hi/Lo/Busy/Done after every edge. Directed cases pin absolute values.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         Clk;
  logic         Reset;
  logic         Start;
  logic [1:0]   Op;
  logic [W-1:0] OpA;
  logic [W-1:0] OpB;
  logic         HiWrite;
  logic         LoWrite;
  logic [W-1:0] WrData;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;
  logic         Busy;
  logic         Done;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WrData(WrData),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
  endtask

  // Architectural result {hi, lo} of one operation.
  function automatic logic [63:0] refOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    case (op)
      2'd0: begin sp = sa * sb; return sp; end
      2'd1: begin up = ua * ub; return up; end
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Model state, updated at each rising edge from the inputs seen there.
  logic [31:0] expHi, expLo, pendHi, pendLo;
  logic        expDone;
  int          remain = 0;
  bit          modelValid = 0;

  initial begin
    logic [63:0] r;
    forever begin
      @(posedge Clk);
      if (Reset) begin
        expHi = 0; expLo = 0; expDone = 0; remain = 0; modelValid = 1;
      end else begin
        expDone = 0;
        if (remain > 0) begin
          remain--;
          if (remain == 0) begin
            expHi = pendHi; expLo = pendLo; expDone = 1;
          end
        end else if (Start) begin
          r = refOp(Op, OpA, OpB);
          pendHi = r[63:32];
          pendLo = r[31:0];
          remain = W + 1;
        end else begin
          if (HiWrite) expHi = WrData;
          if (LoWrite) expLo = WrData;
        end
      end
      #1;
      if (modelValid) begin
        check("cmp_hi",   Hi, expHi);
        check("cmp_lo",   Lo, expLo);
        check("cmp_busy", 32'(Busy), 32'(remain > 0));
        check("cmp_done", 32'(Done), 32'(expDone));
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      4: return 32'($urandom_range(0, 15));
      5: return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic startOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Op = op; OpA = a; OpB = b;
    tick();
    Start = 1'b0;
  endtask

  // Waits for Busy to drop. Returns busy cycles seen and Done pulses,
  // including the one expected in the cycle Busy falls.
  task automatic waitIdle(output int busyCycles, output int dones);
    busyCycles = 0;
    dones = 0;
    for (int i = 0; i < 40 && Busy; i++) begin
      busyCycles++;
      if (Done) dones++;
      tick();
    end
    check("busy_timeout", 32'(Busy), 32'd0);
    if (Done) dones++;
  endtask

  task automatic directedOp(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eHi, input logic [31:0] eLo);
    int bc, dn;
    startOp(op, a, b);
    waitIdle(bc, dn);
    check({name, "_busy_cycles"}, 32'(bc), 32'd33);
    check({name, "_done_at_fall"}, 32'(Done), 32'd1);
    check({name, "_done_count"}, 32'(dn), 32'd1);
    check({name, "_hi"}, Hi, eHi);
    check({name, "_lo"}, Lo, eLo);
    tick();
    check({name, "_done_clear"}, 32'(Done), 32'd0);
  endtask

  initial begin
    int bc, dn;
    Reset = 1'b1; Start = 1'b0; Op = 2'd0; OpA = '0; OpB = '0;
    HiWrite = 1'b0; LoWrite = 1'b0; WrData = '0;
    tick();
    tick();
    Reset = 1'b0;
    check("reset_hi", Hi, 32'd0);
    check("reset_lo", Lo, 32'd0);
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_done", 32'(Done), 32'd0);

    // Randomised traffic: launches, ignored launches, MTHI/MTLO, rare resets.
    for (int c = 0; c < 3000; c++) begin
      Start   = ($urandom_range(0, 7) == 0);
      Op      = 2'($urandom_range(0, 3));
      OpA     = pick();
      OpB     = pick();
      HiWrite = ($urandom_range(0, 5) == 0);
      LoWrite = ($urandom_range(0, 5) == 0);
      WrData  = $urandom;
      Reset   = ($urandom_range(0, 599) == 0);
      tick();
    end
    Reset = 1'b1; Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
    tick();
    Reset = 1'b0;

    directedOp("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    directedOp("mult_neg",  2'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    directedOp("div_neg",   2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    directedOp("divu",      2'd3, 32'd7,         32'd2,         32'd1,         32'd3);
    directedOp("divu_zero", 2'd3, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF);
    directedOp("div_ovf",   2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);

    // Inputs changed mid-operation must have no effect.
    startOp(2'd1, 32'd5, 32'd6);
    tick(); tick(); tick();
    Start = 1'b1; Op = 2'd3; OpA = 32'h1234; HiWrite = 1'b1; WrData = 32'hAAAA;
    tick();
    Start = 1'b0; HiWrite = 1'b0;
    waitIdle(bc, dn);
    check("ignore_hi", Hi, 32'd0);
    check("ignore_lo", Lo, 32'd30);
    check("ignore_done_count", 32'(dn), 32'd1);
    tick();
    check("ignore_done_clear", 32'(Done), 32'd0);

    // MTHI and MTLO together while idle.
    HiWrite = 1'b1; LoWrite = 1'b1; WrData = 32'h55;
    tick();
    HiWrite = 1'b0; LoWrite = 1'b0;
    check("mt_hi", Hi, 32'h55);
    check("mt_lo", Lo, 32'h55);
    check("mt_done", 32'(Done), 32'd0);

    // Reset in the middle of an operation discards it.
    startOp(2'd0, 32'h1234_5678, 32'hFFFF_0001);
    for (int i = 0; i < 9; i++) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_hi", Hi, 32'd0);
    check("midrst_lo", Lo, 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done) dn++;
      tick();
    end
    check("midrst_no_done", 32'(dn), 32'd0);
    directedOp("after_rst", 2'd1, 32'd3, 32'd4, 32'd0, 32'd12);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", checks, passes);
    $fatal(1);
  end

endmodule
